// File: rtl/pdp8_tty.sv
// pdp8_tty -- KL8E-style console teletype controller for the PDP-8.
// Decodes keyboard (device 03) and printer (device 04) IOTs, raises skip
// and interrupt requests, and runs an 8N1 UART paced by a 16x baud strobe.
// Optional build macro TT_LOOPBACK_EN: when defined, the receiver listens
// to the transmitter output instead of uart_in.
`timescale 1ns/1ps

module pdp8_tty #(
  parameter logic [3:0] EXEC_STATE = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        brgclk,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [5:0]  io_select,
  input  logic [11:0] io_data_in,
  output logic        io_selected,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_interrupt,
  output logic        io_skip,
  input  logic        uart_in,
  output logic        uart_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Controller state
  logic       kbd_flag, tpr_flag, ie;
  logic [7:0] rx_buf, tx_buf;

  // Transmitter
  logic [1:0] tx_state;
  logic [3:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;
  logic       tx_pend, tx_out, tx_busy, tx_done;

  // Receiver
  logic [1:0] rx_state;
  logic [3:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_shift;
  logic       rx_s1, rx_s2, rx_s3, rx_done, rx_line;

  // IOT decode
  logic       kbd_sel, tpr_sel, kie, commit;
  logic       kbd_clr, tpr_clr, tpr_tfl, tpc, ie_wr;
  logic [2:0] iop;

  // Bits of the instruction word and AC that this device never looks at.
  logic unused_bits;
  assign unused_bits = ^{mb[11:3], io_data_in[11:8]};

  assign iop     = mb[2:0];
  assign kbd_sel = iot && (io_select == 6'o03);
  assign tpr_sel = iot && (io_select == 6'o04);
  assign kie     = kbd_sel && (iop == 3'b101);
  assign commit  = (kbd_sel || tpr_sel) && (state == EXEC_STATE);

  // KCC/KRB clear the keyboard flag, as does the bare KCF (6030); KIE does not.
  assign kbd_clr = commit && kbd_sel && !kie && (iop[1] || iop == 3'b000);
  assign tpr_clr = commit && tpr_sel && iop[1];
  assign tpr_tfl = commit && tpr_sel && (iop == 3'b000);
  assign tpc     = commit && tpr_sel && iop[2];
  assign ie_wr   = commit && kie;

`ifdef TT_LOOPBACK_EN
  assign rx_line = tx_out;
`else
  assign rx_line = uart_in;
`endif

  assign tx_busy  = tx_pend || (tx_state != S_IDLE);
  assign tx_done  = brgclk && (tx_state == S_STOP) && (tx_cnt == 4'd15);
  assign uart_out = tx_out;

  // IOT-visible outputs: pure decode of the bus and the flag/buffer registers.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    io_selected   = kbd_sel || tpr_sel;
    io_data_out   = 12'o0000;
    io_data_avail = 1'b0;
    io_skip       = 1'b0;
    if (kbd_sel && !kie) begin
      io_skip       = iop[0] && kbd_flag;
      io_data_avail = iop[1] || iop[2];
      if (iop[2]) io_data_out = {4'b0000, rx_buf};
    end else if (tpr_sel) begin
      io_skip = iop[0] && tpr_flag;
    end
  end

  assign io_interrupt = ie && (kbd_flag || tpr_flag);

  // Flags and interrupt enable; a hardware set beats an IOT clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      kbd_flag <= 1'b0;
      tpr_flag <= 1'b0;
      ie       <= 1'b1;
    end else begin
      kbd_flag <= rx_done || (kbd_flag && !kbd_clr);
      tpr_flag <= tx_done || tpr_tfl || (tpr_flag && !tpr_clr);
      if (ie_wr) ie <= io_data_in[0];
    end
  end

  // Transmitter: TPC arms a pending start, the next baud tick drops the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx_buf   <= 8'h00;
      tx_pend  <= 1'b0;
      tx_out   <= 1'b1;
    end else begin
      if (tpc && !tx_busy) begin
        tx_buf  <= io_data_in[7:0];
        tx_pend <= 1'b1;
      end
      if (brgclk) begin
        case (tx_state)
          S_IDLE: begin
            if (tx_pend) begin
              tx_state <= S_START;
              tx_out   <= 1'b0;
              tx_cnt   <= 4'd0;
              tx_shift <= tx_buf;
              tx_pend  <= 1'b0;
            end
          end
          S_START: begin
            tx_cnt <= tx_cnt + 4'd1;
            if (tx_cnt == 4'd15) begin
              tx_state <= S_DATA;
              tx_out   <= tx_shift[0];
              tx_bit   <= 3'd0;
            end
          end
          S_DATA: begin
            tx_cnt <= tx_cnt + 4'd1;
            if (tx_cnt == 4'd15) begin
              if (tx_bit == 3'd7) begin
                tx_state <= S_STOP;
                tx_out   <= 1'b1;
              end else begin
                tx_bit   <= tx_bit + 3'd1;
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_out   <= tx_shift[1];
              end
            end
          end
          default: begin
            tx_cnt <= tx_cnt + 4'd1;
            if (tx_cnt == 4'd15) tx_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Receiver: synchronize, detect the start edge, then sample mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= 4'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_buf   <= 8'h00;
      rx_done  <= 1'b0;
    end else begin
      rx_s1   <= rx_line;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      rx_done <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_state <= S_START;
            rx_cnt   <= 4'd0;
          end
        end
        S_START: begin
          if (brgclk) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd7) begin
              rx_cnt   <= 4'd0;
              rx_bit   <= 3'd0;
              rx_state <= rx_s2 ? S_IDLE : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (brgclk) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
              if (rx_bit == 3'd7) rx_state <= S_STOP;
            end
          end
        end
        default: begin
          if (brgclk) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
              rx_state <= S_IDLE;
              // A bad stop bit discards the character and leaves the flag alone.
              if (rx_s2) begin
                rx_buf  <= rx_shift;
                rx_done <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8_tty.sv
// tb_pdp8_tty -- directed self-checking bench for the console teletype.
`timescale 1ns/1ps

module tb_pdp8_tty;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        brgclk = 1'b1;
  logic        iot = 1'b0;
  logic [3:0]  state = 4'd0;
  logic [11:0] mb = 12'o0;
  logic [5:0]  io_select = 6'o0;
  logic [11:0] io_data_in = 12'o0;
  logic        uart_in = 1'b1;
  logic        io_selected, io_data_avail, io_interrupt, io_skip, uart_out;
  logic [11:0] io_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Outputs captured during the most recent IOT, before its commit edge.
  logic        o_sel, o_skip, o_avail;
  logic [11:0] o_data;

  pdp8_tty #(.EXEC_STATE(4'd1)) dut (
    .clk(clk), .reset(reset), .brgclk(brgclk), .iot(iot), .state(state),
    .mb(mb), .io_select(io_select), .io_data_in(io_data_in),
    .io_selected(io_selected), .io_data_out(io_data_out),
    .io_data_avail(io_data_avail), .io_interrupt(io_interrupt),
    .io_skip(io_skip), .uart_in(uart_in), .uart_out(uart_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  // One IOT, held for a single commit edge; enters and leaves on a negedge.
  task automatic do_iot(input logic [11:0] code, input logic [11:0] ac);
    iot        = 1'b1;
    mb         = code;
    io_select  = code[8:3];
    io_data_in = ac;
    state      = 4'd1;
    #1;
    o_sel   = io_selected;
    o_skip  = io_skip;
    o_avail = io_data_avail;
    o_data  = io_data_out;
    @(posedge clk);
    @(negedge clk);
    iot        = 1'b0;
    mb         = 12'o0;
    io_select  = 6'o0;
    io_data_in = 12'o0;
    state      = 4'd0;
  endtask

  // 8N1 frame with brgclk every cycle: 16 clocks per bit.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = d[i];
      repeat (16) @(negedge clk);
    end
    uart_in = stop;
    repeat (16) @(negedge clk);
    uart_in = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  initial begin
    logic       found;
    logic [7:0] tx_val;

    repeat (3) @(negedge clk);
    check("rst_uart_out", uart_out, 1);
    check("rst_interrupt", io_interrupt, 0);
    check("rst_selected_idle", io_selected, 0);
    check("rst_data_out", io_data_out, 0);
    reset = 1'b0;
    @(negedge clk);

`ifdef TT_LOOPBACK_EN
    do_iot(12'o6046, 12'o0132);
    repeat (200) @(negedge clk);
    do_iot(12'o6031, 12'o0);
    check("lb_ksf_skip", o_skip, 1);
    do_iot(12'o6036, 12'o0);
    check("lb_krb_data", o_data, 12'o0132);
    check("lb_krb_avail", o_avail, 1);
    check("lb_uart_idle", uart_out, 1);
    do_iot(12'o6031, 12'o0);
    check("lb_ksf_after_krb", o_skip, 0);
`else
    // Idle device: no skips
    do_iot(12'o6041, 12'o0);
    check("tsf_idle_skip", o_skip, 0);
    check("tsf_selected", o_sel, 1);
    do_iot(12'o6031, 12'o0);
    check("ksf_idle_skip", o_skip, 0);
    check("idle_uart_out", uart_out, 1);

    // Receive 'A'
    send_frame(8'h41, 1'b1);
    check("rx_interrupt", io_interrupt, 1);
    do_iot(12'o6031, 12'o0);
    check("rx_ksf_skip", o_skip, 1);
    do_iot(12'o6036, 12'o0);
    check("krb_data", o_data, 12'o0101);
    check("krb_avail", o_avail, 1);
    do_iot(12'o6031, 12'o0);
    check("ksf_after_krb", o_skip, 0);
    check("int_after_krb", io_interrupt, 0);

    // Transmit 0125 -> byte 0x55; a second TPC while busy must not disturb it
    do_iot(12'o6046, 12'o0125);
    check("tpc_data_out", o_data, 0);
    check("tpc_avail", o_avail, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (uart_out == 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    check("tx_start_seen", found, 1);
    do_iot(12'o6046, 12'o0377);
    repeat (7) @(negedge clk);
    check("tx_start_bit", uart_out, 0);
    tx_val = 8'h55;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      check($sformatf("tx_bit%0d", i), uart_out, tx_val[i]);
    end
    repeat (16) @(negedge clk);
    check("tx_stop_bit", uart_out, 1);
    do_iot(12'o6041, 12'o0);
    check("tsf_before_done", o_skip, 0);
    repeat (10) @(negedge clk);
    do_iot(12'o6041, 12'o0);
    check("tsf_after_done", o_skip, 1);
    do_iot(12'o6042, 12'o0);
    do_iot(12'o6041, 12'o0);
    check("tsf_after_tcf", o_skip, 0);
    repeat (200) @(negedge clk);
    check("tx_idle_after_busy_tpc", uart_out, 1);

    // TFL sets the printer flag; KIE masks/unmasks the interrupt
    do_iot(12'o6040, 12'o0);
    do_iot(12'o6041, 12'o0);
    check("tfl_skip", o_skip, 1);
    do_iot(12'o6035, 12'o0);
    check("kie_off_interrupt", io_interrupt, 0);
    check("kie_avail", o_avail, 0);
    do_iot(12'o6035, 12'o1);
    check("kie_on_interrupt", io_interrupt, 1);
    do_iot(12'o6042, 12'o0);
    check("int_after_tcf", io_interrupt, 0);

    // Framing error: character discarded, rx_buf keeps 'A'
    send_frame(8'h5A, 1'b0);
    do_iot(12'o6031, 12'o0);
    check("frame_err_skip", o_skip, 0);
    do_iot(12'o6034, 12'o0);
    check("frame_err_rx_buf", o_data, 12'o0101);

    // Short start glitch is rejected, then a good frame still lands
    uart_in = 1'b0;
    repeat (5) @(negedge clk);
    uart_in = 1'b1;
    repeat (200) @(negedge clk);
    do_iot(12'o6031, 12'o0);
    check("glitch_skip", o_skip, 0);
    send_frame(8'h7E, 1'b1);
    do_iot(12'o6031, 12'o0);
    check("rx2_skip", o_skip, 1);
    do_iot(12'o6034, 12'o0);
    check("krs_data", o_data, 12'o0176);
    do_iot(12'o6031, 12'o0);
    check("krs_keeps_flag", o_skip, 1);
    do_iot(12'o6030, 12'o0);
    do_iot(12'o6031, 12'o0);
    check("kcf_clears", o_skip, 0);

    // Reset mid-transmission aborts the frame
    do_iot(12'o6046, 12'o0177);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_abort_line", uart_out, 1);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    do_iot(12'o6041, 12'o0);
    check("reset_abort_no_flag", o_skip, 0);
    check("reset_abort_uart", uart_out, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
